// File: rtl/pc_gen_if.sv
// rtl/pc_gen_if.sv - fetch-side PC generator bus with requester and generator modports
interface pc_gen_if #(
    parameter int XLEN = 32
);
    logic            fetch_ready;
    logic            ilen_16;
    logic            br_valid;
    logic [XLEN-1:0] br_target;
    logic            trap_valid;
    logic [XLEN-1:0] trap_vector;
    logic            halt_req;
    logic            resume_req;
    logic [XLEN-1:0] current_pc;
    logic [XLEN-1:0] next_pc;
    logic            pc_valid;
    logic            flush;
    logic            misalign_exc;
    logic [XLEN-1:0] misalign_addr;
    logic [1:0]      state;

    modport master (
        output fetch_ready, ilen_16, br_valid, br_target, trap_valid, trap_vector,
               halt_req, resume_req,
        input  current_pc, next_pc, pc_valid, flush, misalign_exc, misalign_addr, state
    );

    modport slave (
        input  fetch_ready, ilen_16, br_valid, br_target, trap_valid, trap_vector,
               halt_req, resume_req,
        output current_pc, next_pc, pc_valid, flush, misalign_exc, misalign_addr, state
    );
endinterface

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - program counter generator with redirect, halt and misalign fault handling
module pc_gen #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              C_EXT        = 0
) (
    input  logic   sys_clk,
    input  logic   sys_rst,
    pc_gen_if.slave bus
);
    localparam bit HAS_C = (C_EXT != 0);

    typedef enum logic [1:0] {
        ST_RESET  = 2'b00,
        ST_RUN    = 2'b01,
        ST_HALTED = 2'b10,
        ST_FAULT  = 2'b11
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            flush_q, flush_d;
    logic            mexc_q, mexc_d;
    logic [XLEN-1:0] maddr_q, maddr_d;

    logic [XLEN-1:0] step;
    logic [XLEN-1:0] seq_pc;
    logic [XLEN-1:0] trap_pc;
    logic            br_misaligned;

    always_comb begin
        step          = (HAS_C && bus.ilen_16) ? XLEN'(2) : XLEN'(4);
        seq_pc        = pc_q + step;
        trap_pc       = bus.trap_vector & ~XLEN'(3);
        br_misaligned = HAS_C ? bus.br_target[0] : (bus.br_target[1:0] != 2'b00);
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        flush_d = 1'b0;
        mexc_d  = 1'b0;
        maddr_d = maddr_q;
        unique case (state_q)
            ST_RESET: state_d = ST_RUN;
            ST_RUN: begin
                if (bus.trap_valid) begin
                    pc_d    = trap_pc;
                    flush_d = 1'b1;
                end else if (bus.br_valid) begin
                    // A misaligned target never reaches fetch; the PC stays put and we fault.
                    if (br_misaligned) begin
                        mexc_d  = 1'b1;
                        maddr_d = bus.br_target;
                        state_d = ST_FAULT;
                    end else begin
                        pc_d    = bus.br_target;
                        flush_d = 1'b1;
                    end
                end else if (bus.halt_req) begin
                    state_d = ST_HALTED;
                end else if (bus.fetch_ready) begin
                    pc_d = seq_pc;
                end
            end
            ST_HALTED: begin
                if (bus.resume_req) state_d = ST_RUN;
            end
            ST_FAULT: begin
                if (bus.trap_valid) begin
                    pc_d    = trap_pc;
                    flush_d = 1'b1;
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RESET;
        endcase
    end

    always_ff @(negedge sys_clk) begin
        if (sys_rst) begin
            state_q <= ST_RESET;
            pc_q    <= RESET_VECTOR;
            flush_q <= 1'b0;
            mexc_q  <= 1'b0;
            maddr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            flush_q <= flush_d;
            mexc_q  <= mexc_d;
            maddr_q <= maddr_d;
        end
    end

    assign bus.current_pc    = pc_q;
    assign bus.next_pc       = seq_pc;
    assign bus.pc_valid      = (state_q == ST_RUN);
    assign bus.flush         = flush_q;
    assign bus.misalign_exc  = mexc_q;
    assign bus.misalign_addr = maddr_q;
    assign bus.state         = state_q;
endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - directed bench for pc_gen with IALIGN=4 and IALIGN=2 instances
module tb_pc_gen;
    logic sys_clk;
    logic sys_rst;
    int   n_chk;
    int   n_pass;

    pc_gen_if #(.XLEN(32)) bus0 ();
    pc_gen_if #(.XLEN(32)) bus1 ();

    pc_gen #(.XLEN(32), .RESET_VECTOR(32'h0), .C_EXT(0)) dut0 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .bus(bus0.slave));
    pc_gen #(.XLEN(32), .RESET_VECTOR(32'h0), .C_EXT(1)) dut1 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .bus(bus1.slave));

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    // Inputs change on the rising edge; the DUT acts on the falling edge; outputs are read on the next rising edge.
    task automatic step();
        @(negedge sys_clk);
        @(posedge sys_clk);
    endtask

    task automatic clear_inputs();
        bus0.fetch_ready = 0; bus0.ilen_16 = 0; bus0.br_valid = 0; bus0.br_target = '0;
        bus0.trap_valid = 0; bus0.trap_vector = '0; bus0.halt_req = 0; bus0.resume_req = 0;
        bus1.fetch_ready = 0; bus1.ilen_16 = 0; bus1.br_valid = 0; bus1.br_target = '0;
        bus1.trap_valid = 0; bus1.trap_vector = '0; bus1.halt_req = 0; bus1.resume_req = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        sys_rst = 1;
        bus0.trap_valid = 1; bus0.trap_vector = 32'h900; bus0.fetch_ready = 1;
        step(); step();
        n_chk++; if (bus0.state !== 2'b00) $display("FAIL rst_state: got %b want 00", bus0.state); else n_pass++;
        n_chk++; if (bus0.current_pc !== 32'h0) $display("FAIL rst_pc: got %h want 0", bus0.current_pc); else n_pass++;
        n_chk++; if (bus0.pc_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", bus0.pc_valid); else n_pass++;
        n_chk++; if (bus0.flush !== 1'b0) $display("FAIL rst_flush: got %b want 0", bus0.flush); else n_pass++;
        n_chk++; if (bus0.misalign_exc !== 1'b0) $display("FAIL rst_mexc: got %b want 0", bus0.misalign_exc); else n_pass++;
        n_chk++; if (bus0.misalign_addr !== 32'h0) $display("FAIL rst_maddr: got %h want 0", bus0.misalign_addr); else n_pass++;
        n_chk++; if (bus1.state !== 2'b00) $display("FAIL rst_state1: got %b want 00", bus1.state); else n_pass++;
        clear_inputs();
    endtask

    task automatic test_sequential();
        bus0.fetch_ready = 1; bus0.ilen_16 = 1;
        sys_rst = 0;
        step();
        n_chk++; if (bus0.state !== 2'b01) $display("FAIL seq_state: got %b want 01", bus0.state); else n_pass++;
        n_chk++; if (bus0.current_pc !== 32'h0) $display("FAIL seq_pc0: got %h want 0", bus0.current_pc); else n_pass++;
        n_chk++; if (bus0.pc_valid !== 1'b1) $display("FAIL seq_valid: got %b want 1", bus0.pc_valid); else n_pass++;
        step();
        n_chk++; if (bus0.current_pc !== 32'h4) $display("FAIL seq_pc1: got %h want 4", bus0.current_pc); else n_pass++;
        step();
        n_chk++; if (bus0.current_pc !== 32'h8) $display("FAIL seq_pc2: got %h want 8", bus0.current_pc); else n_pass++;
        n_chk++; if (bus0.next_pc !== 32'hC) $display("FAIL seq_next_noc: got %h want c", bus0.next_pc); else n_pass++;
        bus0.fetch_ready = 0;
        step();
        n_chk++; if (bus0.current_pc !== 32'h8) $display("FAIL seq_hold: got %h want 8", bus0.current_pc); else n_pass++;
        clear_inputs();
    endtask

    task automatic test_cext();
        bus1.br_valid = 1; bus1.br_target = 32'h100;
        step();
        n_chk++; if (bus1.current_pc !== 32'h100) $display("FAIL c_br: got %h want 100", bus1.current_pc); else n_pass++;
        n_chk++; if (bus1.flush !== 1'b1) $display("FAIL c_flush: got %b want 1", bus1.flush); else n_pass++;
        bus1.br_valid = 0; bus1.fetch_ready = 1; bus1.ilen_16 = 1;
        #1;
        n_chk++; if (bus1.next_pc !== 32'h102) $display("FAIL c_next16: got %h want 102", bus1.next_pc); else n_pass++;
        step();
        n_chk++; if (bus1.current_pc !== 32'h102) $display("FAIL c_pc16: got %h want 102", bus1.current_pc); else n_pass++;
        n_chk++; if (bus1.flush !== 1'b0) $display("FAIL c_flush_off: got %b want 0", bus1.flush); else n_pass++;
        bus1.ilen_16 = 0;
        step();
        n_chk++; if (bus1.current_pc !== 32'h106) $display("FAIL c_pc32: got %h want 106", bus1.current_pc); else n_pass++;
        bus1.fetch_ready = 0; bus1.br_valid = 1; bus1.br_target = 32'h10A;
        step();
        n_chk++; if (bus1.current_pc !== 32'h10A) $display("FAIL c_br_half: got %h want 10a", bus1.current_pc); else n_pass++;
        n_chk++; if (bus1.misalign_exc !== 1'b0) $display("FAIL c_half_noexc: got %b want 0", bus1.misalign_exc); else n_pass++;
        bus1.br_target = 32'h10B;
        step();
        n_chk++; if (bus1.state !== 2'b11) $display("FAIL c_odd_state: got %b want 11", bus1.state); else n_pass++;
        n_chk++; if (bus1.misalign_addr !== 32'h10B) $display("FAIL c_odd_addr: got %h want 10b", bus1.misalign_addr); else n_pass++;
        n_chk++; if (bus1.current_pc !== 32'h10A) $display("FAIL c_odd_pc: got %h want 10a", bus1.current_pc); else n_pass++;
        clear_inputs();
    endtask

    task automatic test_priority();
        bus0.br_valid = 1; bus0.br_target = 32'h200;
        bus0.trap_valid = 1; bus0.trap_vector = 32'h803; bus0.fetch_ready = 1;
        step();
        n_chk++; if (bus0.current_pc !== 32'h800) $display("FAIL pri_pc: got %h want 800", bus0.current_pc); else n_pass++;
        n_chk++; if (bus0.flush !== 1'b1) $display("FAIL pri_flush: got %b want 1", bus0.flush); else n_pass++;
        clear_inputs();
        step();
        n_chk++; if (bus0.flush !== 1'b0) $display("FAIL pri_flush_pulse: got %b want 0", bus0.flush); else n_pass++;
        n_chk++; if (bus0.current_pc !== 32'h800) $display("FAIL pri_hold: got %h want 800", bus0.current_pc); else n_pass++;
    endtask

    task automatic test_misalign();
        bus0.br_valid = 1; bus0.br_target = 32'h202; bus0.fetch_ready = 1;
        step();
        n_chk++; if (bus0.misalign_exc !== 1'b1) $display("FAIL mis_exc: got %b want 1", bus0.misalign_exc); else n_pass++;
        n_chk++; if (bus0.misalign_addr !== 32'h202) $display("FAIL mis_addr: got %h want 202", bus0.misalign_addr); else n_pass++;
        n_chk++; if (bus0.state !== 2'b11) $display("FAIL mis_state: got %b want 11", bus0.state); else n_pass++;
        n_chk++; if (bus0.current_pc !== 32'h800) $display("FAIL mis_pc: got %h want 800", bus0.current_pc); else n_pass++;
        n_chk++; if (bus0.flush !== 1'b0) $display("FAIL mis_noflush: got %b want 0", bus0.flush); else n_pass++;
        bus0.br_target = 32'h300;
        step();
        n_chk++; if (bus0.misalign_exc !== 1'b0) $display("FAIL mis_pulse: got %b want 0", bus0.misalign_exc); else n_pass++;
        n_chk++; if (bus0.misalign_addr !== 32'h202) $display("FAIL mis_addr_hold: got %h want 202", bus0.misalign_addr); else n_pass++;
        n_chk++; if (bus0.current_pc !== 32'h800) $display("FAIL mis_fault_hold: got %h want 800", bus0.current_pc); else n_pass++;
        n_chk++; if (bus0.pc_valid !== 1'b0) $display("FAIL mis_valid: got %b want 0", bus0.pc_valid); else n_pass++;
        bus0.br_valid = 0; bus0.trap_valid = 1; bus0.trap_vector = 32'h400;
        step();
        n_chk++; if (bus0.current_pc !== 32'h400) $display("FAIL mis_trap_pc: got %h want 400", bus0.current_pc); else n_pass++;
        n_chk++; if (bus0.state !== 2'b01) $display("FAIL mis_trap_state: got %b want 01", bus0.state); else n_pass++;
        clear_inputs();
    endtask

    task automatic test_halt();
        bus0.fetch_ready = 1; bus0.halt_req = 1;
        step();
        n_chk++; if (bus0.state !== 2'b10) $display("FAIL halt_state: got %b want 10", bus0.state); else n_pass++;
        n_chk++; if (bus0.pc_valid !== 1'b0) $display("FAIL halt_valid: got %b want 0", bus0.pc_valid); else n_pass++;
        n_chk++; if (bus0.current_pc !== 32'h400) $display("FAIL halt_pc: got %h want 400", bus0.current_pc); else n_pass++;
        bus0.halt_req = 0; bus0.br_valid = 1; bus0.br_target = 32'h500;
        bus0.trap_valid = 1; bus0.trap_vector = 32'h600;
        step();
        n_chk++; if (bus0.current_pc !== 32'h400) $display("FAIL halt_ignore_pc: got %h want 400", bus0.current_pc); else n_pass++;
        n_chk++; if (bus0.flush !== 1'b0) $display("FAIL halt_ignore_flush: got %b want 0", bus0.flush); else n_pass++;
        bus0.br_valid = 0; bus0.trap_valid = 0; bus0.resume_req = 1;
        step();
        n_chk++; if (bus0.state !== 2'b01) $display("FAIL resume_state: got %b want 01", bus0.state); else n_pass++;
        n_chk++; if (bus0.current_pc !== 32'h400) $display("FAIL resume_pc: got %h want 400", bus0.current_pc); else n_pass++;
        clear_inputs();
    endtask

    task automatic test_wrap();
        bus0.br_valid = 1; bus0.br_target = 32'hFFFF_FFFC;
        step();
        n_chk++; if (bus0.current_pc !== 32'hFFFF_FFFC) $display("FAIL wrap_br: got %h want fffffffc", bus0.current_pc); else n_pass++;
        bus0.br_valid = 0; bus0.fetch_ready = 1;
        step();
        n_chk++; if (bus0.current_pc !== 32'h0) $display("FAIL wrap_pc: got %h want 0", bus0.current_pc); else n_pass++;
        n_chk++; if (bus0.misalign_exc !== 1'b0) $display("FAIL wrap_exc: got %b want 0", bus0.misalign_exc); else n_pass++;
        n_chk++; if (bus0.state !== 2'b01) $display("FAIL wrap_state: got %b want 01", bus0.state); else n_pass++;
        clear_inputs();
    endtask

    task automatic test_reset_override();
        bus0.br_valid = 1; bus0.br_target = 32'h1;
        step();
        n_chk++; if (bus0.state !== 2'b11) $display("FAIL ovr_fault: got %b want 11", bus0.state); else n_pass++;
        bus0.br_valid = 0; bus0.trap_valid = 1; bus0.trap_vector = 32'h700;
        sys_rst = 1;
        step();
        n_chk++; if (bus0.state !== 2'b00) $display("FAIL ovr_state: got %b want 00", bus0.state); else n_pass++;
        n_chk++; if (bus0.current_pc !== 32'h0) $display("FAIL ovr_pc: got %h want 0", bus0.current_pc); else n_pass++;
        n_chk++; if (bus0.misalign_addr !== 32'h0) $display("FAIL ovr_maddr: got %h want 0", bus0.misalign_addr); else n_pass++;
        n_chk++; if (bus0.flush !== 1'b0) $display("FAIL ovr_flush: got %b want 0", bus0.flush); else n_pass++;
        clear_inputs();
        sys_rst = 0;
        step();
        n_chk++; if (bus0.state !== 2'b01) $display("FAIL ovr_release: got %b want 01", bus0.state); else n_pass++;
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        sys_rst = 1;
        clear_inputs();
        @(posedge sys_clk);
        test_reset();
        test_sequential();
        test_cext();
        test_priority();
        test_misalign();
        test_halt();
        test_wrap();
        test_reset_override();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter XLEN, default 32, PC and target width in bits (allowed: 32, 64).
REQ-002 SHALL have parameter RESET_VECTOR, default 0, PC value loaded by reset (bits [1:0] SHALL be 0).
REQ-003 SHALL have parameter C_EXT, default 0, 1 = 16-bit instructions supported (IALIGN=2), 0 = IALIGN=4.
REQ-004 SHALL have port sys_clk  in  1  single clock; all state updates on falling edge.
REQ-005 SHALL have port sys_rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port fetch_ready  in  1  fetch accepts current_pc this cycle; permits sequential advance.
REQ-007 SHALL have port ilen_16  in  1  instruction at current_pc is 16-bit; ignored when C_EXT=0.
REQ-008 SHALL have ports br_valid  in  1 and br_target  in  XLEN: branch/jump redirect request and target.
REQ-009 SHALL have ports trap_valid  in  1 and trap_vector  in  XLEN: trap redirect request and handler address.
REQ-010 SHALL have ports halt_req  in  1 (level) and resume_req  in  1 (pulse): debug halt and resume.
REQ-011 SHALL have port current_pc  out  XLEN  registered PC presented to fetch.
REQ-012 SHALL have port next_pc  out  XLEN  current_pc + step, where step = 2 if (C_EXT && ilen_16), else 4.
REQ-013 SHALL have port pc_valid  out  1  current_pc is fetchable (state RUN only).
REQ-014 SHALL have port flush  out  1  registered one-cycle pulse after any accepted redirect.
REQ-015 SHALL have ports misalign_exc  out  1 and misalign_addr  out  XLEN: registered pulse and offending target.
REQ-016 SHALL have port state  out  2  encoding RESET=00, RUN=01, HALTED=10, FAULT=11.

Function
REQ-017 SHALL be a four-state machine: RESET -> RUN on the first edge with sys_rst=0; pc unchanged on that edge.
REQ-018 In RUN, priority SHALL be trap_valid > br_valid > halt_req > sequential advance.
REQ-019 In RUN, trap_valid SHALL load current_pc <= {trap_vector[XLEN-1:2],2'b00} and assert flush next cycle.
REQ-020 In RUN, br_valid with an aligned target SHALL load current_pc <= br_target and assert flush, independent of fetch_ready.
REQ-021 A target is misaligned if br_target[1:0]!=0 (C_EXT=0) or br_target[0]!=0 (C_EXT=1).
REQ-022 A misaligned br_valid SHALL leave current_pc unchanged, pulse misalign_exc, latch misalign_addr=br_target, and enter FAULT.
REQ-023 In FAULT, pc_valid=0 and current_pc SHALL hold; only trap_valid leaves FAULT (to RUN, with a trap load per REQ-019).
REQ-024 In RUN with no redirect and halt_req=1, the block SHALL enter HALTED with current_pc held.
REQ-025 In HALTED, trap_valid and br_valid SHALL be ignored; resume_req SHALL return to RUN with no PC change.
REQ-026 In RUN with no redirect or halt, fetch_ready=1 SHALL advance current_pc <= next_pc; fetch_ready=0 SHALL hold it.
REQ-027 PC arithmetic SHALL be modulo 2^XLEN; an all-ones-region PC SHALL wrap to 0 without an error.
REQ-028 flush and misalign_exc SHALL each be high for exactly one cycle per event and low otherwise.
REQ-029 misalign_addr SHALL hold its last latched value until the next misaligned event or reset.

Reset
REQ-030 While sys_rst=1 on an edge: state=RESET, current_pc=RESET_VECTOR, pc_valid=0, flush=0, misalign_exc=0, misalign_addr=0.
REQ-031 Reset SHALL override all other inputs in every state, including mid-redirect and FAULT.

Verification
REQ-032 Reset, then 3 edges with fetch_ready=1 (C_EXT=0, RESET_VECTOR=0) -> current_pc sequence 0, 0, 4, 8; state 00 then 01.
REQ-033 C_EXT=1, pc=0x100, ilen_16=1 then 0, fetch_ready=1 -> current_pc 0x102 then 0x106.
REQ-034 br_valid=1 and trap_valid=1 on the same edge, br_target=0x200, trap_vector=0x803 -> current_pc=0x800, flush one cycle.
REQ-035 C_EXT=0, br_target=0x202 -> misalign_exc pulse, misalign_addr=0x202, state=11, pc held; then trap_vector=0x400 -> pc=0x400, state=01.
REQ-036 halt_req=1 in RUN -> state=10, pc_valid=0, br_valid ignored; resume_req -> state=01, pc unchanged.
REQ-037 XLEN=32, pc=0xFFFFFFFC, fetch_ready=1 -> current_pc=0x00000000, with no exception.
